serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 153 +++++++++++++++
 tb/tb_serial_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
// consumed LSB-first at one bit per clock through a full-add slice built
// from two half_adder cells and an OR gate, and the full-width sum and
// carry-out are published together with a one-cycle done strobe.
//
// Handshake: start is a request that is only looked at in IDLE; a start
// seen while busy or done is dropped, never queued. done is high for
// exactly one cycle, and sum/carry are new in that cycle. They hold their
// value until the next completion or reset.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Bits already produced, oldest at bit 0. Only WIDTH-1 are kept because
  // the last bit goes straight from the slice into the sum register.
  logic [WIDTH-2:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  // Full-add slice: half_adder(a,b) -> (p,g); half_adder(p,c) -> (s,t).
  logic ha0_s, ha0_c;
  logic s_bit, ha1_c;
  logic c_next;

  half_adder u_ha0 (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  half_adder u_ha1 (
    .a_i (ha0_s),
    .b_i (c_q),
    .s_o (s_bit),
    .c_o (ha1_c)
  );

  assign c_next = ha0_c | ha1_c;

  // Next-state and datapath: everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = (WIDTH-1)'({s_bit, s_sh_q} >> 1);
        c_d    = c_next;
        if (cnt_q == CNT_LAST) begin
          // Result and carry are published in the same edge so the outputs
          // never show a half-updated value. The counter stays put rather
          // than wrapping.
          sum_d   = {s_bit, s_sh_q};
          carry_d = c_next;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, aborting any add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign state_dbg = state_q;

endmodule

// One-bit half adder cell.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): reset values, several operand
// patterns, timing of busy/done, mid-run start/operand changes, reset abort
// and back-to-back issue with start held high.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       carry;
  logic [1:0] state_dbg;

  int total;
  int bad;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry     (carry),
    .state_dbg (state_dbg)
  );

  // Clock and safety timeout
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Driver: issue one add, scramble a/b after capture, wait (bounded) for done.
  // lat is edges from acceptance to done (-1 if done never came).
  task automatic do_add(input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] s, output logic c,
                        output int lat, output int busy_n, output int out_chg);
    logic [7:0] s0;
    logic       c0;
    s0 = sum;
    c0 = carry;
    lat = -1;
    busy_n = 0;
    out_chg = 0;
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
        lat = n - 1;
        break;
      end
      if (sum !== s0 || carry !== c0) out_chg = 1;
    end
    s = sum;
    c = carry;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h exp=00", sum); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [7:0] s;
    logic c;
    int lat, bn, chg;
    do_add(8'h00, 8'h00, s, c, lat, bn, chg);
    total++; if (s !== 8'h00) begin bad++; $display("FAIL zero_sum got=%h exp=00", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL zero_carry got=%b exp=0", c); end
    total++; if (lat != 8) begin bad++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    total++; if (bn != 8) begin bad++; $display("FAIL zero_busy_cycles got=%0d exp=8", bn); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b exp=0", done); end
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL zero_back_idle got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_ripple();
    logic [7:0] s;
    logic c;
    int lat, bn, chg;
    do_add(8'hFF, 8'h01, s, c, lat, bn, chg);
    total++; if (s !== 8'h00) begin bad++; $display("FAIL ripple_sum got=%h exp=00", s); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL ripple_carry got=%b exp=1", c); end
    total++; if (lat != 8) begin bad++; $display("FAIL ripple_latency got=%0d exp=8", lat); end
  endtask

  task automatic test_patterns();
    logic [7:0] s;
    logic c;
    int lat, bn, chg;
    do_add(8'hA5, 8'h5A, s, c, lat, bn, chg);
    total++; if (s !== 8'hFF) begin bad++; $display("FAIL a5_5a_sum got=%h exp=ff", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL a5_5a_carry got=%b exp=0", c); end
    total++; if (chg != 0) begin bad++; $display("FAIL a5_5a_hold got=%0d exp=0", chg); end
    do_add(8'hFF, 8'hFF, s, c, lat, bn, chg);
    total++; if (s !== 8'hFE) begin bad++; $display("FAIL ff_ff_sum got=%h exp=fe", s); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL ff_ff_carry got=%b exp=1", c); end
    total++; if (chg != 0) begin bad++; $display("FAIL ff_ff_hold got=%0d exp=0", chg); end
    total++; if (bn != 8) begin bad++; $display("FAIL ff_ff_busy_cycles got=%0d exp=8", bn); end
  endtask

  task automatic test_mid_run();
    int dones;
    logic [7:0] s_at;
    logic c_at;
    dones = 0;
    s_at = 8'hXX;
    c_at = 1'bx;
    @(negedge clk);
    start = 1'b1;
    a = 8'h10;
    b = 8'h20;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 3) begin
        start = 1'b1;
        a = 8'h01;
        b = 8'h01;
      end
      if (n == 6) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        s_at = sum;
        c_at = carry;
      end
    end
    total++; if (dones != 1) begin bad++; $display("FAIL midrun_done_count got=%0d exp=1", dones); end
    total++; if (s_at !== 8'h30) begin bad++; $display("FAIL midrun_sum got=%h exp=30", s_at); end
    total++; if (c_at !== 1'b0) begin bad++; $display("FAIL midrun_carry got=%b exp=0", c_at); end
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [7:0] s;
    logic c;
    int lat, bn, chg;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b exp=0", done); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL rstmid_sum got=%h exp=00", sum); end
    total++; if (carry !== 1'b0) begin bad++; $display("FAIL rstmid_carry got=%b exp=0", carry); end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
    total++; if (sum !== 8'h00) begin bad++; $display("FAIL rstmid_sum_after got=%h exp=00", sum); end
    do_add(8'h03, 8'h04, s, c, lat, bn, chg);
    total++; if (s !== 8'h07) begin bad++; $display("FAIL fresh_sum got=%h exp=07", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL fresh_carry got=%b exp=0", c); end
    total++; if (lat != 8) begin bad++; $display("FAIL fresh_latency got=%0d exp=8", lat); end
  endtask

  task automatic test_back_to_back();
    int dones;
    int first_n;
    int prev_n;
    dones = 0;
    first_n = -1;
    prev_n = -1;
    @(negedge clk);
    start = 1'b1;
    a = 8'h80;
    b = 8'h80;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL b2b_sum[%0d] got=%h exp=00", dones, sum); end
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL b2b_carry[%0d] got=%b exp=1", dones, carry); end
        if (prev_n < 0) first_n = n;
        else begin
          total++;
          if (n - prev_n != 10) begin bad++; $display("FAIL b2b_interval got=%0d exp=10", n - prev_n); end
        end
        prev_n = n;
      end
    end
    start = 1'b0;
    total++; if (dones != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", dones); end
    total++; if (first_n != 9) begin bad++; $display("FAIL b2b_first_done got=%0d exp=9", first_n); end
    repeat (12) @(negedge clk);
    total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL b2b_final_idle got=%0d exp=0", state_dbg); end
  endtask

  // Test sequence and final report
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    test_reset();
    test_zero();
    test_ripple();
    test_patterns();
    test_mid_run();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
